// File: rtl/doc_keyboard_editor_pkg.sv
// Shared definitions for the keyboard document editor: PS/2 set-2 scancodes,
// FSM state and arrow direction encodings, and the printable character set.
package doc_keyboard_editor_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK,
    ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    DIR_LEFT,
    DIR_RIGHT,
    DIR_UP,
    DIR_DOWN
  } arrow_dir_t;

  // Must stay in step with the glyph table of the VGA text display.
  function automatic logic is_printable_code(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    case (code)
      SC_SPACE, 8'h52, 8'h41, 8'h49, 8'h16,
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/doc_keyboard_editor_if.sv
// Scancode input and RAM write/cursor output bundle of the document editor.
// The editor is the slave; the scancode source / display side is the master.
interface doc_keyboard_editor_if;

  logic [7:0] iSCAN_DATA;
  logic       iSCAN_VALID;
  logic       iCLEAR;
  logic       oWE;
  logic [9:0] oWADDR;
  logic [7:0] oWDATA;
  logic [9:0] oDOC_PTR;
  logic [9:0] oSCROLL;
  logic       oBUSY;

  modport master (
    output iSCAN_DATA, iSCAN_VALID, iCLEAR,
    input  oWE, oWADDR, oWDATA, oDOC_PTR, oSCROLL, oBUSY
  );

  modport slave (
    input  iSCAN_DATA, iSCAN_VALID, iCLEAR,
    output oWE, oWADDR, oWDATA, oDOC_PTR, oSCROLL, oBUSY
  );

endinterface

// File: rtl/doc_keyboard_editor_scancode_classifier.sv
// Combinational decode of one scancode byte into the editor's action classes.
module doc_keyboard_editor_scancode_classifier
  import doc_keyboard_editor_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_printable,
  output logic       is_bksp,
  output logic       is_enter,
  output arrow_dir_t arrow_dir,
  output logic       is_arrow
);

  always_comb begin
    is_printable = is_printable_code(code);
    is_bksp      = (code == SC_BKSP);
    is_enter     = (code == SC_ENTER);
    arrow_dir    = DIR_LEFT;
    is_arrow     = 1'b1;
    case (code)
      SC_LEFT:  arrow_dir = DIR_LEFT;
      SC_RIGHT: arrow_dir = DIR_RIGHT;
      SC_UP:    arrow_dir = DIR_UP;
      SC_DOWN:  arrow_dir = DIR_DOWN;
      default:  is_arrow  = 1'b0;
    endcase
  end

endmodule

// File: rtl/doc_keyboard_editor.sv
// PS/2 scancode driven document editor: tracks the cursor and scroll offset and
// issues document RAM writes for typed characters, backspace and full clears.
module doc_keyboard_editor
  import doc_keyboard_editor_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 512,
  parameter int unsigned WRITE_AREA = 510,
  parameter int unsigned ROW_LEN    = 18,
  parameter int unsigned COL_LEN    = 29
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  doc_keyboard_editor_if.slave bus
);

  localparam int unsigned PW = 10;
  localparam int unsigned CW = $clog2(ROW_LEN);

  localparam logic [PW-1:0] LAST_PTR = PW'(WRITE_AREA - 1);
  localparam logic [PW-1:0] LAST_ROW = PW'((WRITE_AREA - 1) / ROW_LEN);
  localparam logic [CW-1:0] LAST_COL = CW'((WRITE_AREA - 1) % ROW_LEN);
  localparam logic [PW-1:0] LAST_RAM = PW'(RAM_SIZE - 1);
  localparam logic [PW-1:0] ROW_STEP = PW'(ROW_LEN);
  localparam logic [CW-1:0] COL_MAX  = CW'(ROW_LEN - 1);
  localparam logic [PW-1:0] WIN_LEN  = PW'(COL_LEN);
  localparam logic [PW-1:0] WIN_TOP  = PW'(COL_LEN - 1);

  state_t        state;
  logic [PW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] ptr;
  logic [PW-1:0] scroll;
  logic [PW-1:0] clr_addr;
  logic          we;
  logic [PW-1:0] waddr;
  logic [7:0]    wdata;
  logic          busy;

  logic       is_printable;
  logic       is_bksp;
  logic       is_enter;
  arrow_dir_t arrow_dir;
  logic       is_arrow;

  doc_keyboard_editor_scancode_classifier u_classifier (
    .code         (bus.iSCAN_DATA),
    .is_printable (is_printable),
    .is_bksp      (is_bksp),
    .is_enter     (is_enter),
    .arrow_dir    (arrow_dir),
    .is_arrow     (is_arrow)
  );

  // Neighbouring positions derived incrementally from row/col so no divider is needed.
  logic          at_start;
  logic          at_end;
  logic [PW-1:0] fwd_row;
  logic [CW-1:0] fwd_col;
  logic [PW-1:0] back_row;
  logic [CW-1:0] back_col;
  logic [PW-1:0] next_line;
  logic [PW-1:0] down_ptr;

  always_comb begin
    at_start  = (ptr == '0);
    at_end    = (ptr == LAST_PTR);
    fwd_row   = (col == COL_MAX) ? row + 1'b1 : row;
    fwd_col   = (col == COL_MAX) ? '0 : col + 1'b1;
    back_row  = (col == '0) ? row - 1'b1 : row;
    back_col  = (col == '0) ? COL_MAX : col - 1'b1;
    next_line = ptr - PW'(col) + ROW_STEP;
    down_ptr  = ptr + ROW_STEP;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= ST_IDLE;
      row      <= '0;
      col      <= '0;
      ptr      <= '0;
      scroll   <= '0;
      clr_addr <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
    end else begin
      we   <= 1'b0;
      busy <= 1'b0;

      if (row < scroll) begin
        scroll <= row;
      end else if (row >= scroll + WIN_LEN) begin
        scroll <= row - WIN_TOP;
      end

      unique case (state)
        ST_CLEAR: begin
          we    <= 1'b1;
          busy  <= 1'b1;
          waddr <= clr_addr;
          wdata <= '0;
          if (clr_addr == LAST_RAM) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            row    <= '0;
            col    <= '0;
            scroll <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end

        ST_IDLE: begin
          if (bus.iCLEAR) begin
            // Address 0 is written on the entry edge; clr_addr then walks from 1.
            state    <= ST_CLEAR;
            we       <= 1'b1;
            busy     <= 1'b1;
            waddr    <= '0;
            wdata    <= '0;
            clr_addr <= PW'(1);
          end else if (bus.iSCAN_VALID) begin
            if (bus.iSCAN_DATA == SC_BREAK) begin
              state <= ST_BRK;
            end else if (bus.iSCAN_DATA == SC_EXT) begin
              state <= ST_EXT;
            end else if (is_printable) begin
              we    <= 1'b1;
              waddr <= ptr;
              wdata <= bus.iSCAN_DATA;
              if (!at_end) begin
                ptr <= ptr + 1'b1;
                row <= fwd_row;
                col <= fwd_col;
              end
            end else if (is_bksp) begin
              if (!at_start) begin
                we    <= 1'b1;
                waddr <= ptr - 1'b1;
                wdata <= '0;
                ptr   <= ptr - 1'b1;
                row   <= back_row;
                col   <= back_col;
              end
            end else if (is_enter) begin
              if (next_line < PW'(WRITE_AREA)) begin
                ptr <= next_line;
                row <= row + 1'b1;
                col <= '0;
              end
            end
          end
        end

        ST_EXT: begin
          if (bus.iSCAN_VALID) begin
            if (bus.iSCAN_DATA == SC_BREAK) begin
              state <= ST_EXT_BRK;
            end else begin
              state <= ST_IDLE;
              if (is_arrow) begin
                unique case (arrow_dir)
                  DIR_LEFT: begin
                    if (!at_start) begin
                      ptr <= ptr - 1'b1;
                      row <= back_row;
                      col <= back_col;
                    end
                  end
                  DIR_RIGHT: begin
                    if (!at_end) begin
                      ptr <= ptr + 1'b1;
                      row <= fwd_row;
                      col <= fwd_col;
                    end
                  end
                  DIR_UP: begin
                    if (row != '0) begin
                      ptr <= ptr - ROW_STEP;
                      row <= row - 1'b1;
                    end
                  end
                  DIR_DOWN: begin
                    if (down_ptr < PW'(WRITE_AREA)) begin
                      ptr <= down_ptr;
                      row <= row + 1'b1;
                    end else begin
                      ptr <= LAST_PTR;
                      row <= LAST_ROW;
                      col <= LAST_COL;
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
        end

        ST_BRK, ST_EXT_BRK: begin
          if (bus.iSCAN_VALID) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oWE      = we;
  assign bus.oWADDR   = waddr;
  assign bus.oWDATA   = wdata;
  assign bus.oDOC_PTR = ptr;
  assign bus.oSCROLL  = scroll;
  assign bus.oBUSY    = busy;

endmodule
